mem_ctrl: RTL

//  Responder side of the core's memory-manager interface. Sits between the spark core and a

---
 rtl/mem_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Memory-manager responder: arbitrates core fetch and MEM-stage requests onto a
// byte-wide single-port RAM, assembling little-endian 32-bit read words.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  input  logic [1:0]        rwtype_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [7:0]        ram_data_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  input  logic [7:0]        mem_din,
  output logic [RAM_AW-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [RAM_AW-1:0] base;
  logic [7:0]        b0, b1, b2;

  logic              mem_rd_req;
  logic              mem_wr_req;
  logic              req;
  logic [RAM_AW-1:0] req_addr;

  // Only the low RAM_AW address bits reach the RAM; the rest are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rom_addr_i[ADDR_W-1:RAM_AW], ram_addr_i[ADDR_W-1:RAM_AW]};

  always_comb begin
    mem_rd_req = (rwtype_i == 2'b01);
    mem_wr_req = (rwtype_i == 2'b10);
    req        = mem_rd_req | mem_wr_req | pc_valid_i;
    // MEM-stage requests win over instruction fetch.
    req_addr   = (mem_rd_req | mem_wr_req) ? ram_addr_i[RAM_AW-1:0]
                                           : rom_addr_i[RAM_AW-1:0];
  end

  // The core may only advance on DONE; in reset the core must not be held.
  assign stall_o = rst & ((state == RD) | (state == WR) | ((state == IDLE) & req));

  // NOTE: every register here uses non-blocking assignment so all state updates on an
  // edge see the pre-edge values; the byte holding registers are reset too since they
  // are few flops and keep data_o deterministic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      base     <= '0;
      b0       <= 8'h00;
      b1       <= 8'h00;
      b2       <= 8'h00;
      data_o   <= 32'h0;
      mem_a    <= '0;
      mem_dout <= 8'h00;
      mem_wr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            base  <= req_addr;
            mem_a <= req_addr;
            cnt   <= 3'd0;
            if (mem_wr_req) begin
              mem_dout <= ram_data_i;
              mem_wr   <= 1'b1;
              state    <= WR;
            end else begin
              mem_wr <= 1'b0;
              state  <= RD;
            end
          end
        end
        RD: begin
          // RAM data trails the address by one cycle, so capture lags issue by one count.
          if (cnt < 3'd3) mem_a <= base + RAM_AW'(cnt + 3'd1);
          case (cnt)
            3'd1: b0 <= mem_din;
            3'd2: b1 <= mem_din;
            3'd3: b2 <= mem_din;
            3'd4: begin
              data_o <= {mem_din, b2, b1, b0};
              state  <= DONE;
            end
            default: ;
          endcase
          cnt <= cnt + 3'd1;
        end
        WR: begin
          mem_wr <= 1'b0;
          state  <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
